// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op-class helpers shared by the ALU/MDU
package alu_pkg;
  localparam int OP_W = 5;
  typedef enum logic [OP_W-1:0] {
    ADD    = 5'b00000,
    SUB    = 5'b00001,
    AND    = 5'b00010,
    OR     = 5'b00011,
    XOR    = 5'b00100,
    SLL    = 5'b00101,
    SRL    = 5'b00110,
    SRA    = 5'b00111,
    SLT    = 5'b01000,
    SLTU   = 5'b01001,
    MUL    = 5'b10000,
    MULH   = 5'b10001,
    MULHSU = 5'b10010,
    MULHU  = 5'b10011,
    DIV    = 5'b10100,
    DIVU   = 5'b10101,
    REM    = 5'b10110,
    REMU   = 5'b10111
  } alu_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
  function automatic logic is_mext(alu_op_e op);
    return op[4:3] == 2'b10;
  endfunction
  function automatic logic is_div(alu_op_e op);
    return op[4:2] == 3'b101;
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider on operand magnitudes
module mdu_iter import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);
  logic [SHW:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic r_nq, r_nr;
  alu_op_e r_op;
  logic w_an, w_bn, w_ge;
  logic [WIDTH-1:0] w_ma, w_mb, w_nhi, w_nlo;
  logic [WIDTH:0] w_sum, w_trial;
  logic [2*WIDTH-1:0] w_sp;
  // one mul/div step, sign fix-up applied to the post-step value so the last step's result is usable at once
  always_comb begin
    w_an = op inside {MUL, MULH, MULHSU, DIV, REM} && a[WIDTH-1];
    w_bn = op inside {MUL, MULH, DIV, REM} && b[WIDTH-1];
    w_ma = w_an ? -a : a;
    w_mb = w_bn ? -b : b;
    w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_trial = {r_hi, r_lo[WIDTH-1]};
    w_ge = w_trial >= {1'b0, r_b};
    w_nhi = is_div(r_op) ? (w_ge ? WIDTH'(w_trial - {1'b0, r_b}) : w_trial[WIDTH-1:0]) : w_sum[WIDTH:1];
    w_nlo = is_div(r_op) ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};
    w_sp = r_nq ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    result = is_div(r_op) ? (r_op[1] ? (r_nr ? -w_nhi : w_nhi) : (r_nq ? -w_nlo : w_nlo))
                          : (r_op[1:0] == 2'b00 ? w_sp[WIDTH-1:0] : w_sp[2*WIDTH-1:WIDTH]);
    done = !r_cnt[SHW] && &r_cnt[SHW-1:0];
  end
  // load magnitudes on start, then step until the counter reaches WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {1'b1, {SHW{1'b0}}};
      r_hi <= '0;
      r_lo <= '0;
      r_b <= '0;
      r_nq <= 1'b0;
      r_nr <= 1'b0;
      r_op <= ADD;
    end else if (start) begin
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= w_ma;
      r_b <= w_mb;
      r_nq <= w_an ^ w_bn;
      r_nr <= w_an;
      r_op <= op;
    end else if (!r_cnt[SHW]) begin
      r_cnt <= r_cnt + 1'b1;
      r_hi <= w_nhi;
      r_lo <= w_nlo;
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: RV32I ALU plus iterative RV32M unit behind valid/ready handshakes
module alu_mdu import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  alu_op_e          ALUctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             EQ,
  output logic             LT,
  output logic             LTU
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  state_e r_state, w_nstate;
  logic r_live, r_eq, r_lt, r_ltu;
  logic [WIDTH-1:0] r_result;
  logic w_eq, w_lt, w_ltu, w_known, w_div0, w_ovf, w_fast, w_accept, w_start, w_done;
  logic [WIDTH-1:0] w_alu, w_imm, w_mres;
  logic [SHW-1:0] w_shamt;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk(clk), .rst_n(rst_n), .start(w_start), .op(ALUctrl),
    .a(SrcA), .b(SrcB), .done(w_done), .result(w_mres)
  );

  assign in_ready = r_live && !flush && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_start = w_accept && !w_fast;
  assign out_valid = r_state == S_DONE;
  assign ALUResult = r_result;
  assign EQ = r_eq;
  assign LT = r_lt;
  assign LTU = r_ltu;

  // single-cycle results: base ops, divide-by-zero and signed overflow division
  always_comb begin
    w_shamt = SrcB[SHW-1:0];
    w_eq = SrcA == SrcB;
    w_lt = $signed(SrcA) < $signed(SrcB);
    w_ltu = SrcA < SrcB;
    w_known = 1'b1;
    w_alu = '0;
    case (ALUctrl)
      ADD:  w_alu = SrcA + SrcB;
      SUB:  w_alu = SrcA - SrcB;
      AND:  w_alu = SrcA & SrcB;
      OR:   w_alu = SrcA | SrcB;
      XOR:  w_alu = SrcA ^ SrcB;
      SLL:  w_alu = SrcA << w_shamt;
      SRL:  w_alu = SrcA >> w_shamt;
      SRA:  w_alu = $unsigned($signed(SrcA) >>> w_shamt);
      SLT:  w_alu = {{(WIDTH-1){1'b0}}, w_lt};
      SLTU: w_alu = {{(WIDTH-1){1'b0}}, w_ltu};
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: w_alu = '0;
      default: w_known = 1'b0;
    endcase
    w_div0 = is_div(ALUctrl) && SrcB == '0;
    w_ovf = ALUctrl inside {DIV, REM} && SrcA == MIN && SrcB == '1;
    w_fast = !is_mext(ALUctrl) || w_div0 || w_ovf;
    w_imm = w_div0 ? (ALUctrl[1] ? SrcA : '1) : w_ovf ? (ALUctrl[1] ? '0 : MIN) : w_alu;
  end

  // handshake FSM next state; flush wins over everything but reset
  always_comb begin
    w_nstate = r_state;
    if (flush) w_nstate = S_IDLE;
    else if (w_accept) w_nstate = w_fast ? S_DONE : is_div(ALUctrl) ? S_DIV : S_MUL;
    else if (r_state == S_DONE && out_ready) w_nstate = S_IDLE;
    else if ((r_state == S_MUL || r_state == S_DIV) && w_done) w_nstate = S_DONE;
  end

  // state, output result and flags registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live <= 1'b0;
      r_result <= '0;
      r_eq <= 1'b0;
      r_lt <= 1'b0;
      r_ltu <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_live <= 1'b1;
      if (w_accept) begin
        r_eq <= w_eq && w_known;
        r_lt <= w_lt && w_known;
        r_ltu <= w_ltu && w_known;
        if (w_fast) r_result <= w_imm;
      end else if (!flush && (r_state == S_MUL || r_state == S_DIV) && w_done) begin
        r_result <= w_mres;
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu covering base ops, M ops, handshakes and aborts
module tb_alu_mdu;
  import alu_pkg::*;
  typedef struct packed {logic [31:0] res; logic eq, lt, ltu;} exp_t;
  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, EQ, LT, LTU;
  logic [31:0] SrcA = '0, SrcB = '0, ALUResult;
  alu_op_e ALUctrl = ADD;
  exp_t sb_q[$];
  int errors = 0, checks = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUctrl(ALUctrl), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .EQ(EQ), .LT(LT), .LTU(LTU)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] sa, sb;
    logic [63:0] t;
    sa = $signed(a);
    sb = $signed(b);
    r.eq = a == b;
    r.lt = $signed(a) < $signed(b);
    r.ltu = a < b;
    r.res = '0;
    t = '0;
    case (op)
      5'h00: r.res = a + b;
      5'h01: r.res = a - b;
      5'h02: r.res = a & b;
      5'h03: r.res = a | b;
      5'h04: r.res = a ^ b;
      5'h05: r.res = a << b[4:0];
      5'h06: r.res = a >> b[4:0];
      5'h07: r.res = $signed(a) >>> b[4:0];
      5'h08: r.res = {31'b0, r.lt};
      5'h09: r.res = {31'b0, r.ltu};
      5'h10: begin t = sa * sb; r.res = t[31:0]; end
      5'h11: begin t = sa * sb; r.res = t[63:32]; end
      5'h12: begin t = sa * $signed({32'b0, b}); r.res = t[63:32]; end
      5'h13: begin t = {32'b0, a} * {32'b0, b}; r.res = t[63:32]; end
      5'h14: begin t = sa / sb; r.res = (b == 0) ? 32'hFFFFFFFF : t[31:0]; end
      5'h15: r.res = (b == 0) ? 32'hFFFFFFFF : a / b;
      5'h16: begin t = sa % sb; r.res = (b == 0) ? a : t[31:0]; end
      5'h17: r.res = (b == 0) ? a : a % b;
      default: begin r.eq = 1'b0; r.lt = 1'b0; r.ltu = 1'b0; end
    endcase
    return r;
  endfunction

  // call aligned just after a rising edge; returns just after the accepting edge
  task automatic accept(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic push);
    int n = 0;
    ALUctrl = alu_op_e'(op);
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout op=%h: in_ready=%b, required 1", op, in_ready);
    end
    @(posedge clk);
    if (push) sb_q.push_back(model(op, a, b));
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: output res=%h with empty scoreboard", name, ALUResult);
    end else begin
      e = sb_q.pop_front();
      if (!out_valid || ALUResult !== e.res || EQ !== e.eq || LT !== e.lt || LTU !== e.ltu) begin
        errors++;
        $display("FAIL %s: got v=%b res=%h eq=%b lt=%b ltu=%b, required v=1 res=%h eq=%b lt=%b ltu=%b",
                 name, out_valid, ALUResult, EQ, LT, LTU, e.res, e.eq, e.lt, e.ltu);
      end
    end
  endtask

  task automatic wait_out(input string name, input int lat, input logic [31:0] want);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s_latency: got %0d, required %0d", name, n, lat); end
    checks++;
    if (ALUResult !== want) begin errors++; $display("FAIL %s_value: got %h, required %h", name, ALUResult, want); end
    collect(name);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (out_valid !== 1'b0 || ALUResult !== '0 || {EQ, LT, LTU} !== 3'b000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s: got v=%b res=%h flags=%b%b%b rdy=%b, required all 0", name, out_valid, ALUResult, EQ, LT, LTU, in_ready);
    end
  endtask

  task automatic check_ready_after_release(input string name);
    @(negedge clk) rst_n = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL %s_rdy_before_clk: got %b, required 0", name, in_ready); end
    @(posedge clk); #1 checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_rdy_after_clk: got %b, required 1", name, in_ready); end
  endtask

  task automatic check_no_output(input string name, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin @(negedge clk); seen |= out_valid; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL %s: out_valid rose=%b, required 0", name, seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (2) @(posedge clk);
    check_ready_after_release("reset");
  endtask

  task automatic test_back_to_back();
    accept(5'h00, 32'd5, 32'd7, 1'b1);
    ALUctrl = SUB; SrcA = 32'd3; SrcB = 32'd5; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b, required 1", in_ready); end
    checks++;
    if (ALUResult !== 32'd12) begin errors++; $display("FAIL b2b_add: got %h, required 0000000c", ALUResult); end
    collect("b2b_add");
    @(posedge clk);
    sb_q.push_back(model(5'h01, 32'd3, 32'd5));
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ALUResult !== 32'hFFFFFFFE || {EQ, LT, LTU} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_sub: got res=%h eq=%b lt=%b ltu=%b, required fffffffe 0 1 1", ALUResult, EQ, LT, LTU);
    end
    collect("b2b_sub");
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    accept(5'h11, 32'h80000000, 32'h80000000, 1'b1);
    wait_out("mulh_min", 33, 32'h40000000);
    accept(5'h10, 32'h80000000, 32'h80000000, 1'b1);
    wait_out("mul_min", 33, 32'h00000000);
  endtask

  task automatic test_div();
    accept(5'h14, -32'sd7, 32'd2, 1'b1);
    wait_out("div_neg", 33, 32'hFFFFFFFD);
    accept(5'h16, -32'sd7, 32'd2, 1'b1);
    wait_out("rem_neg", 33, 32'hFFFFFFFF);
    accept(5'h15, 32'd7, 32'd0, 1'b1);
    wait_out("divu_zero", 1, 32'hFFFFFFFF);
    accept(5'h14, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_out("div_ovf", 1, 32'h80000000);
    accept(5'h16, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_out("rem_ovf", 1, 32'h00000000);
  endtask

  task automatic test_shift_unknown();
    accept(5'h07, 32'h80000000, 32'h00000021, 1'b1);
    wait_out("sra_shamt", 1, 32'hC0000000);
    accept(5'h1F, 32'd5, 32'd5, 1'b1);
    wait_out("unknown_op", 1, 32'h00000000);
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    accept(5'h15, 32'd100, 32'd7, 1'b1);
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    checks++;
    if (n != 33) begin errors++; $display("FAIL bp_latency: got %0d, required 33", n); end
    ALUctrl = ADD; SrcA = 32'd1; SrcB = 32'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd14 || {EQ, LT, LTU} !== 3'b000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: got v=%b res=%h flags=%b%b%b rdy=%b, required 1 0000000e 000 0",
                 i, out_valid, ALUResult, EQ, LT, LTU, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
    collect("bp_divu");
    @(posedge clk);
    sb_q.push_back(model(5'h00, 32'd1, 32'd2));
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ALUResult !== 32'd3) begin errors++; $display("FAIL bp_next_add: got %h, required 00000003", ALUResult); end
    collect("bp_add");
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    accept(5'h15, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    ALUctrl = ADD; SrcA = 32'd9; SrcB = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b, required 0", in_ready); end
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check_no_output("flush_no_out", 45);
    accept(5'h00, 32'd20, 32'd22, 1'b1);
    wait_out("flush_next_add", 1, 32'd42);
  endtask

  task automatic test_reset_mid();
    accept(5'h10, 32'd3, 32'd4, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_state");
    check_ready_after_release("reset_mid");
    check_no_output("reset_mid_no_out", 45);
    accept(5'h00, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_out("reset_next_add", 1, 32'd1);
  endtask

  task automatic test_random();
    alu_op_e ops[18] = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
                         MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
    logic [4:0] op;
    logic [31:0] a, b;
    int lat;
    for (int i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 17)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 2) == 0) b = -b;
      lat = (op[4:3] == 2'b10 && b != 0 &&
             !((op == 5'h14 || op == 5'h16) && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 33 : 1;
      accept(op, a, b, 1'b1);
      wait_out($sformatf("rand%0d_op%h", i, op), lat, model(op, a, b).res);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mul();
    test_div();
    test_shift_unknown();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
